// File: rtl/wb_pkg.sv
// Shared types and constants for the pipelined Wishbone MMIO master.
package wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } wb_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [3:0] MMIO_BASE_DEFAULT = 4'h2;

endpackage

// File: rtl/wb_lane_align.sv
// Byte-lane steering for stores, lane extraction and sign/zero extension for loads.
module wb_lane_align
  import wb_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_sel,
  output logic        o_misaligned,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_ld_shift;
  logic        w_ld_sign;

  always_comb begin
    o_st_data    = '0;
    o_sel        = '0;
    o_misaligned = 1'b0;
    unique case (i_st_size)
      SIZE_B: begin
        o_st_data = {4{i_st_data[7:0]}};
        o_sel     = 4'b0001 << i_st_addr_lo;
      end
      SIZE_H: begin
        o_st_data    = {2{i_st_data[15:0]}};
        o_sel        = 4'b0011 << i_st_addr_lo;
        o_misaligned = i_st_addr_lo[0];
      end
      SIZE_W: begin
        o_st_data    = i_st_data;
        o_sel        = 4'b1111;
        o_misaligned = |i_st_addr_lo;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign w_ld_shift = i_ld_raw >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    o_ld_data = w_ld_shift;
    w_ld_sign = 1'b0;
    unique case (i_ld_size)
      SIZE_B: begin
        w_ld_sign = ~i_ld_unsigned & w_ld_shift[7];
        o_ld_data = {{24{w_ld_sign}}, w_ld_shift[7:0]};
      end
      SIZE_H: begin
        w_ld_sign = ~i_ld_unsigned & w_ld_shift[15];
        o_ld_data = {{16{w_ld_sign}}, w_ld_shift[15:0]};
      end
      default: o_ld_data = w_ld_shift;
    endcase
  end

endmodule

// File: rtl/wb_master_pipelined.sv
// Registered Wishbone B4 pipelined master for CPU MMIO loads/stores with
// sub-word lanes, ERR handling and a REQ/WAIT timeout.
module wb_master_pipelined
  import wb_pkg::*;
#(
  parameter int unsigned                  ADDR_WIDTH     = 32,
  parameter int unsigned                  MMIO_TAG_BITS  = 4,
  parameter logic [MMIO_TAG_BITS-1:0]     MMIO_BASE      = MMIO_TAG_BITS'(MMIO_BASE_DEFAULT),
  parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  is_load_instr_i,
  input  logic                  is_store_instr_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  load_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] mmio_address_i,
  input  logic [31:0]           wr_data_i,
  output logic [31:0]           rd_data_o,
  output logic                  rd_valid_o,
  output logic                  bus_error_o,
  output logic                  peripheral_stall_o,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err,
  input  logic [31:0]           i_wb_data
);

  localparam int unsigned       CntW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0]   CntMax = CntW'(TIMEOUT_CYCLES);

  wb_state_e             r_state, w_state_d;
  logic                  r_cyc, w_cyc_d;
  logic                  r_stb, w_stb_d;
  logic                  r_we, w_we_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [31:0]           r_data, w_data_d;
  logic [3:0]            r_sel, w_sel_d;
  logic [1:0]            r_size, w_size_d;
  logic                  r_unsigned, w_unsigned_d;
  logic                  r_err, w_err_d;
  logic [31:0]           r_rd_data, w_rd_data_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;

  logic [CntW-1:0]       w_cnt_inc;
  logic                  w_access;
  logic                  w_misaligned;
  logic [31:0]           w_st_data;
  logic [3:0]            w_sel;
  logic [31:0]           w_ld_data;

  assign w_access = (is_load_instr_i | is_store_instr_i)
                  & (mmio_address_i[ADDR_WIDTH-1 -: MMIO_TAG_BITS] == MMIO_BASE);
  assign w_cnt_inc = r_cnt + CntW'(1);

  wb_lane_align u_lane (
    .i_st_size     (mem_size_i),
    .i_st_addr_lo  (mmio_address_i[1:0]),
    .i_st_data     (wr_data_i),
    .o_st_data     (w_st_data),
    .o_sel         (w_sel),
    .o_misaligned  (w_misaligned),
    .i_ld_size     (r_size),
    .i_ld_addr_lo  (r_addr[1:0]),
    .i_ld_unsigned (r_unsigned),
    .i_ld_raw      (i_wb_data),
    .o_ld_data     (w_ld_data)
  );

  always_comb begin
    w_state_d    = r_state;
    w_cyc_d      = r_cyc;
    w_stb_d      = r_stb;
    w_we_d       = r_we;
    w_addr_d     = r_addr;
    w_data_d     = r_data;
    w_sel_d      = r_sel;
    w_size_d     = r_size;
    w_unsigned_d = r_unsigned;
    w_err_d      = r_err;
    w_rd_data_d  = r_rd_data;
    w_cnt_d      = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_access) begin
          // A simultaneous load+store is handled as a store.
          w_we_d       = is_store_instr_i;
          w_addr_d     = mmio_address_i;
          w_size_d     = mem_size_i;
          w_unsigned_d = load_unsigned_i;
          if (w_misaligned) begin
            w_err_d   = 1'b1;
            w_state_d = StDone;
          end else begin
            w_err_d   = 1'b0;
            w_cyc_d   = 1'b1;
            w_stb_d   = 1'b1;
            w_sel_d   = w_sel;
            w_data_d  = is_store_instr_i ? w_st_data : '0;
            w_cnt_d   = '0;
            w_state_d = StReq;
          end
        end
      end
      StReq: begin
        w_cnt_d = w_cnt_inc;
        if (!i_wb_stall && (i_wb_ack || i_wb_err)) begin
          w_err_d   = i_wb_err;
          w_cyc_d   = 1'b0;
          w_stb_d   = 1'b0;
          w_state_d = StDone;
          if (!i_wb_err && !r_we) w_rd_data_d = w_ld_data;
        end else if (w_cnt_inc == CntMax) begin
          w_err_d   = 1'b1;
          w_cyc_d   = 1'b0;
          w_stb_d   = 1'b0;
          w_state_d = StDone;
        end else if (!i_wb_stall) begin
          w_stb_d   = 1'b0;
          w_state_d = StWait;
        end
      end
      StWait: begin
        w_cnt_d = w_cnt_inc;
        if (i_wb_ack || i_wb_err) begin
          w_err_d   = i_wb_err;
          w_cyc_d   = 1'b0;
          w_state_d = StDone;
          if (!i_wb_err && !r_we) w_rd_data_d = w_ld_data;
        end else if (w_cnt_inc == CntMax) begin
          w_err_d   = 1'b1;
          w_cyc_d   = 1'b0;
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_sel      <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_rd_data  <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cyc      <= w_cyc_d;
      r_stb      <= w_stb_d;
      r_we       <= w_we_d;
      r_addr     <= w_addr_d;
      r_data     <= w_data_d;
      r_sel      <= w_sel_d;
      r_size     <= w_size_d;
      r_unsigned <= w_unsigned_d;
      r_err      <= w_err_d;
      r_rd_data  <= w_rd_data_d;
      r_cnt      <= w_cnt_d;
    end
  end

  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_stb;
  assign o_wb_we   = r_we;
  assign o_wb_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_wb_data = r_data;
  assign o_wb_sel  = r_sel;

  assign rd_data_o   = r_rd_data;
  assign rd_valid_o  = (r_state == StDone) & ~r_we & ~r_err;
  assign bus_error_o = (r_state == StDone) & r_err;

  // Gated by reset so the CPU is released the moment reset asserts.
  assign peripheral_stall_o = rst_ni & (((r_state == StIdle) & w_access)
                                        | (r_state == StReq) | (r_state == StWait));

endmodule

// File: tb/tb_wb_master_pipelined.sv
// Directed bench for wb_master_pipelined: configurable slave, bus-beat and response scoreboards.
module tb_wb_master_pipelined;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
  } beat_t;

  typedef struct {
    logic        err;
    logic        valid;
    logic [31:0] rd;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_load, is_store, load_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mmio_address, wr_data;
  logic [31:0] rd_data;
  logic        rd_valid, bus_error, stall;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall = 1'b0, i_wb_ack = 1'b0, i_wb_err = 1'b0;
  logic [31:0] i_wb_data = '0;

  always #5 clk = ~clk;

  wb_master_pipelined #(
    .ADDR_WIDTH    (32),
    .MMIO_TAG_BITS (4),
    .MMIO_BASE     (4'h2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .is_load_instr_i   (is_load),
    .is_store_instr_i  (is_store),
    .mem_size_i        (mem_size),
    .load_unsigned_i   (load_unsigned),
    .mmio_address_i    (mmio_address),
    .wr_data_i         (wr_data),
    .rd_data_o         (rd_data),
    .rd_valid_o        (rd_valid),
    .bus_error_o       (bus_error),
    .peripheral_stall_o(stall),
    .o_wb_cyc          (o_wb_cyc),
    .o_wb_stb          (o_wb_stb),
    .o_wb_we           (o_wb_we),
    .o_wb_addr         (o_wb_addr),
    .o_wb_data         (o_wb_data),
    .o_wb_sel          (o_wb_sel),
    .i_wb_stall        (i_wb_stall),
    .i_wb_ack          (i_wb_ack),
    .i_wb_err          (i_wb_err),
    .i_wb_data         (i_wb_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  beat_t beat_q[$];
  resp_t resp_q[$];

  // Slave: stall for sl_stall cycles, then respond sl_delay cycles after accept.
  // sl_mode: 0 ack, 1 err, 2 ack+err, 3 silent.
  int          sl_stall = 0, sl_delay = 1, sl_mode = 0;
  logic [31:0] sl_rdata = '0;
  int          s_stall_cnt = 0, s_wcnt = 0;
  bit          s_acc = 0, s_hit = 0;

  always @(negedge clk) begin
    i_wb_stall = 1'b0;
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    i_wb_data  = sl_rdata;
    s_hit      = 0;
    if (!o_wb_cyc) begin
      s_acc       = 0;
      s_stall_cnt = 0;
    end else if (o_wb_stb && !s_acc) begin
      if (s_stall_cnt < sl_stall) begin
        i_wb_stall = 1'b1;
        s_stall_cnt++;
      end else begin
        s_acc  = 1;
        s_wcnt = 0;
        s_hit  = (sl_delay == 0);
      end
    end else if (s_acc) begin
      s_wcnt++;
      s_hit = (s_wcnt == sl_delay);
    end
    if (s_hit) begin
      i_wb_ack = (sl_mode == 0) || (sl_mode == 2);
      i_wb_err = (sl_mode == 1) || (sl_mode == 2);
    end
  end

  // Monitor: counts bus activity, scoreboards accepted beats and result pulses.
  int cyc_cnt = 0, stb_cnt = 0;
  always begin
    beat_t b;
    resp_t r;
    @(negedge clk);
    #2;
    if (o_wb_cyc) cyc_cnt++;
    if (o_wb_stb) stb_cnt++;
    if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
      chk("beat_expected", 32'(beat_q.size() != 0), 32'd1);
      if (beat_q.size() != 0) begin
        b = beat_q.pop_front();
        chk("beat_addr", o_wb_addr, b.addr);
        chk("beat_sel", 32'(o_wb_sel), 32'(b.sel));
        chk("beat_we", 32'(o_wb_we), 32'(b.we));
        if (b.we) chk("beat_data", o_wb_data, b.data);
      end
    end
    if (rd_valid || bus_error) begin
      chk("resp_expected", 32'(resp_q.size() != 0), 32'd1);
      if (resp_q.size() != 0) begin
        r = resp_q.pop_front();
        chk("resp_err", 32'(bus_error), 32'(r.err));
        chk("resp_valid", 32'(rd_valid), 32'(r.valid));
        if (r.valid) chk("resp_rd_data", rd_data, r.rd);
      end
    end
  end

  task automatic access(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input bit bus, input beat_t b, input resp_t r, input int exp_stalls);
    int n;
    @(negedge clk);
    cyc_cnt = 0;
    stb_cnt = 0;
    if (bus) beat_q.push_back(b);
    if (r.err || r.valid) resp_q.push_back(r);
    is_load       = ld;
    is_store      = st;
    mem_size      = sz;
    load_unsigned = uns;
    mmio_address  = a;
    wr_data       = wd;
    #1;
    n = 0;
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stalls));
    chk({tag, "_bus_error"}, 32'(bus_error), 32'(r.err));
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(r.valid));
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam beat_t NoBeat = '{addr: 32'h0, data: 32'h0, sel: 4'h0, we: 1'b0};

  initial begin
    rst_n         = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    mem_size      = 2'b00;
    load_unsigned = 1'b0;
    mmio_address  = '0;
    wr_data       = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rst_stb", 32'(o_wb_stb), 32'd0);
    chk("rst_we", 32'(o_wb_we), 32'd0);
    chk("rst_addr", o_wb_addr, 32'd0);
    chk("rst_data", o_wb_data, 32'd0);
    chk("rst_sel", 32'(o_wb_sel), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    // Word store, ack two cycles after accept.
    sl_stall = 0; sl_delay = 2; sl_mode = 0;
    access("st_word", 0, 1, 2'b10, 0, 32'h2000_0004, 32'hDEAD_BEEF,
           1, beat_t'{32'h2000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1}, resp_t'{1'b0, 1'b0, 32'h0}, 4);

    // Byte loads from lane 3, zero-wait ack.
    sl_delay = 1; sl_rdata = 32'h8012_3456;
    access("ld_byte_u", 1, 0, 2'b00, 1, 32'h2000_0003, 32'h0,
           1, beat_t'{32'h2000_0000, 32'h0, 4'h8, 1'b0}, resp_t'{1'b0, 1'b1, 32'h0000_0080}, 3);
    access("ld_byte_s", 1, 0, 2'b00, 0, 32'h2000_0003, 32'h0,
           1, beat_t'{32'h2000_0000, 32'h0, 4'h8, 1'b0}, resp_t'{1'b0, 1'b1, 32'hFFFF_FF80}, 3);

    sl_rdata = 32'hBEEF_1234;
    access("ld_half_u", 1, 0, 2'b01, 1, 32'h2000_0002, 32'h0,
           1, beat_t'{32'h2000_0000, 32'h0, 4'hC, 1'b0}, resp_t'{1'b0, 1'b1, 32'h0000_BEEF}, 3);
    sl_rdata = 32'h1234_8001;
    access("ld_half_s", 1, 0, 2'b01, 0, 32'h2000_0000, 32'h0,
           1, beat_t'{32'h2000_0000, 32'h0, 4'h3, 1'b0}, resp_t'{1'b0, 1'b1, 32'hFFFF_8001}, 3);

    // Ack in the same cycle the strobe is accepted.
    sl_delay = 0;
    access("st_byte", 0, 1, 2'b00, 0, 32'h2000_0002, 32'h0000_00AB,
           1, beat_t'{32'h2000_0000, 32'hABAB_ABAB, 4'h4, 1'b1}, resp_t'{1'b0, 1'b0, 32'h0}, 2);
    sl_delay = 1;
    access("st_half", 0, 1, 2'b01, 0, 32'h2000_0006, 32'h0000_1234,
           1, beat_t'{32'h2000_0004, 32'h1234_1234, 4'hC, 1'b1}, resp_t'{1'b0, 1'b0, 32'h0}, 3);
    sl_rdata = 32'hCAFE_F00D;
    access("ld_word", 1, 0, 2'b10, 0, 32'h2000_0008, 32'h0,
           1, beat_t'{32'h2000_0008, 32'h0, 4'hF, 1'b0}, resp_t'{1'b0, 1'b1, 32'hCAFE_F00D}, 3);
    repeat (3) @(negedge clk);
    #1;
    chk("rd_data_hold", rd_data, 32'hCAFE_F00D);

    // Misaligned accesses: one stall cycle, error, no bus cycle.
    access("mis_half", 0, 1, 2'b01, 0, 32'h2000_0001, 32'h1111,
           0, NoBeat, resp_t'{1'b1, 1'b0, 32'h0}, 1);
    chk("mis_half_no_cyc", 32'(cyc_cnt), 32'd0);
    access("mis_word", 1, 0, 2'b10, 0, 32'h2000_0002, 32'h0,
           0, NoBeat, resp_t'{1'b1, 1'b0, 32'h0}, 1);
    access("mis_size3", 1, 0, 2'b11, 0, 32'h2000_0000, 32'h0,
           0, NoBeat, resp_t'{1'b1, 1'b0, 32'h0}, 1);

    // Timeout: 5 stalled cycles, then silence until the count reaches 8.
    sl_stall = 5; sl_mode = 3;
    access("timeout", 0, 1, 2'b10, 0, 32'h2000_0010, 32'h5555_AAAA,
           1, beat_t'{32'h2000_0010, 32'h5555_AAAA, 4'hF, 1'b1}, resp_t'{1'b1, 1'b0, 32'h0}, 9);
    chk("timeout_cyc_cycles", 32'(cyc_cnt), 32'd8);
    chk("timeout_stb_cycles", 32'(stb_cnt), 32'd6);
    chk("timeout_cyc_low", 32'(o_wb_cyc), 32'd0);

    // ERR beats a simultaneous ACK in WAIT.
    sl_stall = 0; sl_delay = 1; sl_mode = 2; sl_rdata = 32'h0BAD_0BAD;
    access("ack_err", 1, 0, 2'b10, 0, 32'h2000_000C, 32'h0,
           1, beat_t'{32'h2000_000C, 32'h0, 4'hF, 1'b0}, resp_t'{1'b1, 1'b0, 32'h0}, 3);
    // ERR in REQ while not stalled.
    sl_delay = 0; sl_mode = 1;
    access("err_req", 0, 1, 2'b10, 0, 32'h2000_0020, 32'h7777_7777,
           1, beat_t'{32'h2000_0020, 32'h7777_7777, 4'hF, 1'b1}, resp_t'{1'b1, 1'b0, 32'h0}, 2);

    // Outside the MMIO window: ignored.
    sl_mode = 0; sl_delay = 1;
    access("non_mmio", 1, 0, 2'b10, 0, 32'h1000_0000, 32'h0,
           0, NoBeat, resp_t'{1'b0, 1'b0, 32'h0}, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("non_mmio_no_cyc", 32'(cyc_cnt), 32'd0);

    // Load and store together: store wins.
    access("ld_st", 1, 1, 2'b10, 0, 32'h2000_0014, 32'h1122_3344,
           1, beat_t'{32'h2000_0014, 32'h1122_3344, 4'hF, 1'b1}, resp_t'{1'b0, 1'b0, 32'h0}, 3);

    // Async reset while waiting on a silent slave.
    sl_mode = 3;
    @(negedge clk);
    beat_q.push_back(beat_t'{32'h2000_0018, 32'h0, 4'hF, 1'b0});
    is_load      = 1'b1;
    mem_size     = 2'b10;
    mmio_address = 32'h2000_0018;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_cyc", 32'(o_wb_cyc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("mid_rst_stb", 32'(o_wb_stb), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    is_load = 1'b0;
    #1;
    rst_n = 1'b1;
    sl_mode = 0; sl_rdata = 32'h5A5A_0001;
    access("post_rst_ld", 1, 0, 2'b10, 0, 32'h2000_001C, 32'h0,
           1, beat_t'{32'h2000_001C, 32'h0, 4'hF, 1'b0}, resp_t'{1'b0, 1'b1, 32'h5A5A_0001}, 3);

    repeat (3) @(negedge clk);
    #3;
    chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
